// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch - instruction fetch front end
//
// Turns each pc_update pulse from the PC register into one instruction-memory
// read. It captures the returned word and presents {pc, instruction, fault}
// to decode over a valid/ready handshake.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   curr_pc, pc_update       new fetch address and its one-cycle strobe
//   fetch_rdy                pending slot free (core gates PC next_en with it)
//   flush                    pipeline redirect, discards all fetch state
//   imem_req/addr/gnt        memory request channel (request held until gnt)
//   imem_rvalid/rdata/err    memory response channel
//   inst_valid/ready         decode handshake
//   inst_pc/data/fault       presented instruction; fault[0]=bus, [1]=misalign
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] curr_pc,
    input  logic                 pc_update,
    output logic                 fetch_rdy,
    input  logic                 flush,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    input  logic                 imem_err,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic [CPU_WIDTH-1:0] inst_data,
    output logic [1:0]           inst_fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t               state_r;
    logic                 pend_valid_r;
    logic [CPU_WIDTH-1:0] pend_pc_r;
    logic                 drop_r;      // next response belongs to a flushed fetch
    logic                 dispatch_s;  // pending slot is consumed this cycle
    logic                 pend_aligned_s;

    assign fetch_rdy      = ~pend_valid_r;
    assign pend_aligned_s = (pend_pc_r[1:0] == 2'b00);

    // Decide whether the pending pc starts a new fetch this cycle. Dispatch is
    // possible from IDLE, from OUT as decode takes the current word (no bubble),
    // and from WAIT when a flushed response is being drained.
    always_comb begin
        dispatch_s = 1'b0;
        if (pend_valid_r) begin
            case (state_r)
                ST_IDLE: dispatch_s = 1'b1;
                ST_WAIT: dispatch_s = drop_r & imem_rvalid;
                ST_OUT:  dispatch_s = inst_ready;
                default: dispatch_s = 1'b0;
            endcase
        end else begin
            dispatch_s = 1'b0;
        end
    end

    // Fetch FSM, pending slot and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pend_valid_r <= 1'b0;
            pend_pc_r    <= {CPU_WIDTH{1'b0}};
            drop_r       <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= {CPU_WIDTH{1'b0}};
            inst_valid   <= 1'b0;
            inst_pc      <= {CPU_WIDTH{1'b0}};
            inst_data    <= {CPU_WIDTH{1'b0}};
            inst_fault   <= 2'b00;
        end else if (flush) begin
            // Redirect: forget the slot and the presented word; a pc_update in
            // this cycle belongs to the old stream and is ignored.
            pend_valid_r <= 1'b0;
            inst_valid   <= 1'b0;
            inst_pc      <= {CPU_WIDTH{1'b0}};
            inst_data    <= {CPU_WIDTH{1'b0}};
            inst_fault   <= 2'b00;
            imem_req     <= 1'b0;
            case (state_r)
                ST_REQ: begin
                    if (imem_gnt) begin
                        // Request already accepted: its response must be drained.
                        state_r <= ST_WAIT;
                        drop_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        // The outstanding response arrives right now and is
                        // discarded here, so nothing is left to drain.
                        state_r <= ST_IDLE;
                        drop_r  <= 1'b0;
                    end else begin
                        drop_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            // Pending slot: latest pc wins; a refill in the consume cycle keeps it full.
            if (pc_update) begin
                pend_pc_r    <= curr_pc;
                pend_valid_r <= 1'b1;
            end else if (dispatch_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end

            if (dispatch_s) begin
                drop_r <= 1'b0;
                if (pend_aligned_s) begin
                    state_r    <= ST_REQ;
                    imem_req   <= 1'b1;
                    imem_addr  <= pend_pc_r;
                    inst_valid <= 1'b0;
                end else begin
                    // Misaligned pc never touches memory.
                    state_r    <= ST_OUT;
                    inst_valid <= 1'b1;
                    inst_pc    <= pend_pc_r;
                    inst_data  <= NOP_INST;
                    inst_fault <= 2'b10;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_REQ: begin
                        if (imem_gnt) begin
                            imem_req <= 1'b0;
                            state_r  <= ST_WAIT;
                        end else begin
                            imem_req <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            if (drop_r) begin
                                drop_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end else begin
                                state_r    <= ST_OUT;
                                inst_valid <= 1'b1;
                                inst_pc    <= imem_addr;
                                inst_data  <= imem_err ? NOP_INST : imem_rdata;
                                inst_fault <= imem_err ? 2'b01 : 2'b00;
                            end
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_OUT: begin
                        if (inst_ready) begin
                            inst_valid <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            inst_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch - directed self-checking bench for ifu_fetch.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same
// point, so every check sees the state registered by the preceding edge.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] curr_pc = 32'h0;
    logic        pc_update = 1'b0;
    logic        fetch_rdy;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic [1:0]  inst_fault;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic saw_addr20 = 1'b0;
    logic saw_misaligned_req = 1'b0;

    ifu_fetch #(.CPU_WIDTH(32), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .curr_pc(curr_pc), .pc_update(pc_update),
        .fetch_rdy(fetch_rdy), .flush(flush), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_err(imem_err), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    // Bus monitor: remembers forbidden addresses seen on an issued request.
    always @(posedge clk) begin
        if (imem_req && imem_addr == 32'h0000_0020) saw_addr20 <= 1'b1;
        if (imem_req && imem_addr[1:0] != 2'b00) saw_misaligned_req <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vec_cnt++;
        if ({imem_req, inst_valid, inst_fault, fetch_rdy} !== 5'b00_001) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got req=%b valid=%b fault=%b rdy=%b, exp 0 0 00 1",
                     imem_req, inst_valid, inst_fault, fetch_rdy);
        end
        vec_cnt++;
        if ({imem_addr, inst_pc, inst_data} !== 96'h0) begin
            err_cnt++;
            $display("FAIL reset_data: got addr=%h pc=%h data=%h, exp all 0",
                     imem_addr, inst_pc, inst_data);
        end
    endtask

    task automatic test_single_fetch();
        curr_pc = 32'h0000_0010; pc_update = 1'b1;   // cycle N
        step();                                        // N+1
        pc_update = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b0 || fetch_rdy !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_n1: got req=%b rdy=%b, exp 0 0", imem_req, fetch_rdy);
        end
        step();                                        // N+2
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0010) begin
            err_cnt++;
            $display("FAIL single_req: got req=%b addr=%h, exp 1 00000010", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        step();                                        // N+3
        imem_gnt = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_wait: got req=%b valid=%b, exp 0 0", imem_req, inst_valid);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();                                        // N+4
        imem_rvalid = 1'b0;
        vec_cnt++;
        if ({inst_valid, inst_pc, inst_data, inst_fault} !== {1'b1, 32'h10, 32'h0050_0093, 2'b00}) begin
            err_cnt++;
            $display("FAIL single_out: got v=%b pc=%h data=%h f=%b, exp 1 00000010 00500093 00",
                     inst_valid, inst_pc, inst_data, inst_fault);
        end
    endtask

    task automatic test_decode_stall();
        // OUT holds 0x10; decode is stalled and a second pc arrives.
        curr_pc = 32'h0000_0014; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        vec_cnt++;
        if (fetch_rdy !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_rdy: got %b exp 0", fetch_rdy);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vec_cnt++;
            if ({inst_valid, inst_pc, inst_data, imem_req} !== {1'b1, 32'h10, 32'h0050_0093, 1'b0}) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h data=%h req=%b, exp 1 00000010 00500093 0",
                         i, inst_valid, inst_pc, inst_data, imem_req);
            end
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        vec_cnt++;
        if ({imem_req, imem_addr, inst_valid, fetch_rdy} !== {1'b1, 32'h14, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL back_to_back: got req=%b addr=%h v=%b rdy=%b, exp 1 00000014 0 1",
                     imem_req, imem_addr, inst_valid, fetch_rdy);
        end
        imem_gnt = 1'b1;
        step();                                        // now in WAIT for 0x14
        imem_gnt = 1'b0;
    endtask

    task automatic test_overwrite();
        curr_pc = 32'h0000_0020; pc_update = 1'b1;
        step();
        curr_pc = 32'h0000_0040;
        step();
        pc_update = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0AAA;
        step();
        imem_rvalid = 1'b0;
        vec_cnt++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h14, 32'h0000_0AAA}) begin
            err_cnt++;
            $display("FAIL ovw_out14: got v=%b pc=%h data=%h, exp 1 00000014 00000aaa",
                     inst_valid, inst_pc, inst_data);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0040) begin
            err_cnt++;
            $display("FAIL ovw_req: got req=%b addr=%h, exp 1 00000040", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BBB;
        step();
        imem_rvalid = 1'b0;
        vec_cnt++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h40, 32'h0000_0BBB}) begin
            err_cnt++;
            $display("FAIL ovw_out40: got v=%b pc=%h data=%h, exp 1 00000040 00000bbb",
                     inst_valid, inst_pc, inst_data);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        vec_cnt++;
        if (saw_addr20 !== 1'b0 || inst_valid !== 1'b0 || fetch_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL ovw_idle: got saw20=%b v=%b rdy=%b, exp 0 0 1", saw_addr20, inst_valid, fetch_rdy);
        end
    endtask

    task automatic test_misaligned();
        curr_pc = 32'h0000_0022; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        step();
        vec_cnt++;
        if ({imem_req, inst_valid, inst_pc, inst_data, inst_fault} !==
            {1'b0, 1'b1, 32'h22, 32'h0000_0013, 2'b10}) begin
            err_cnt++;
            $display("FAIL misalign: got req=%b v=%b pc=%h data=%h f=%b, exp 0 1 00000022 00000013 10",
                     imem_req, inst_valid, inst_pc, inst_data, inst_fault);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        vec_cnt++;
        if (saw_misaligned_req !== 1'b0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL misalign_noreq: got sawmis=%b req=%b v=%b, exp 0 0 0",
                     saw_misaligned_req, imem_req, inst_valid);
        end
    endtask

    task automatic test_bus_error();
        curr_pc = 32'h0000_0030; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0; imem_err = 1'b0;
        vec_cnt++;
        if ({inst_valid, inst_pc, inst_data, inst_fault} !== {1'b1, 32'h30, 32'h0000_0013, 2'b01}) begin
            err_cnt++;
            $display("FAIL bus_err: got v=%b pc=%h data=%h f=%b, exp 1 00000030 00000013 01",
                     inst_valid, inst_pc, inst_data, inst_fault);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_flush();
        // Flush in REQ without a grant: request withdrawn, back to IDLE.
        curr_pc = 32'h0000_0060; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        vec_cnt++;
        if (imem_req !== 1'b0 || fetch_rdy !== 1'b1 || inst_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_req: got req=%b rdy=%b v=%b, exp 0 1 0", imem_req, fetch_rdy, inst_valid);
        end
        // Flush in WAIT, new pc next cycle, stale response must be dropped.
        curr_pc = 32'h0000_0050; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        curr_pc = 32'h0000_0080; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b0 || fetch_rdy !== 1'b0 || inst_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_wait: got req=%b rdy=%b v=%b, exp 0 0 0", imem_req, fetch_rdy, inst_valid);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        vec_cnt++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h80}) begin
            err_cnt++;
            $display("FAIL flush_drop: got v=%b req=%b addr=%h, exp 0 1 00000080", inst_valid, imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0080_0113;
        step();
        imem_rvalid = 1'b0;
        vec_cnt++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h80, 32'h0080_0113}) begin
            err_cnt++;
            $display("FAIL flush_next: got v=%b pc=%h data=%h, exp 1 00000080 00800113",
                     inst_valid, inst_pc, inst_data);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        curr_pc = 32'h0000_0090; pc_update = 1'b1;
        step();
        pc_update = 1'b0;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec_cnt++;
        if ({imem_req, imem_addr, inst_valid, fetch_rdy} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL rst_wait: got req=%b addr=%h v=%b rdy=%b, exp 0 00000000 0 1",
                     imem_req, imem_addr, inst_valid, fetch_rdy);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        imem_rvalid = 1'b0;
        step();
        vec_cnt++;
        if ({inst_valid, imem_req, inst_data} !== {1'b0, 1'b0, 32'h0}) begin
            err_cnt++;
            $display("FAIL rst_late_rvalid: got v=%b req=%b data=%h, exp 0 0 00000000",
                     inst_valid, imem_req, inst_data);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_fetch();
        test_decode_stall();
        test_overwrite();
        test_misaligned();
        test_bus_error();
        test_flush();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch front end, the consumer of the PC register's curr_pc / pc_update pair. Each pc_update pulse becomes one instruction-memory read. The block captures the returned word and hands {pc, instruction, fault} to decode over a valid/ready handshake. It also generates fetch_rdy, which the core uses to gate the PC register's next_en.

Parameters:
CPU_WIDTH, 32, width of PC, address and instruction data
NOP_INST, 32'h0000_0013, word presented in inst_data for faulted fetches

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
curr_pc  input  CPU_WIDTH  current PC from PC register
pc_update  input  1  one-cycle pulse: curr_pc holds a new fetch address
fetch_rdy  output  1  pending slot free; core ANDs this into PC next_en
flush  input  1  pipeline redirect; discard all fetch state
imem_req  output  1  memory read request
imem_addr  output  CPU_WIDTH  word-aligned read address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  CPU_WIDTH  read data
imem_err  input  1  bus error, qualified by imem_rvalid
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts
inst_pc  output  CPU_WIDTH  PC of the presented instruction
inst_data  output  CPU_WIDTH  instruction word
inst_fault  output  2  bit0 = bus error, bit1 = misaligned PC

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE; pending slot empty; drop flag clear.
  - Outputs: imem_req=0, imem_addr=0, inst_valid=0, inst_pc=0, inst_data=0, inst_fault=0, fetch_rdy=1.
- Pending slot (one entry, pend_pc):
  - pc_update=1 loads curr_pc and sets pend_valid.
  - If pend_valid is already set, the new pc overwrites the old one (latest wins).
  - fetch_rdy = !pend_valid.
- FSM states: IDLE, REQ, WAIT, OUT.
  - IDLE, pend_valid=1, pend_pc aligned: consume the slot, go to REQ, imem_addr <= pend_pc.
  - IDLE, pend_valid=1, pend_pc[1:0]!=0: consume the slot, go straight to OUT with inst_data=NOP_INST, inst_fault=2'b10. No memory access is made.
  - REQ: imem_req=1 and imem_addr is held stable until imem_gnt; on gnt go to WAIT. imem_req is registered, never combinational from pc_update.
  - WAIT: on imem_rvalid, latch imem_rdata, or NOP_INST with fault 2'b01 if imem_err; go to OUT. While waiting, imem_req=0.
  - OUT: inst_valid=1 with inst_pc/inst_data/inst_fault held stable. On inst_ready, go to IDLE.
  - OUT back-to-back: if inst_ready and pend_valid are both set, go directly to REQ (or back to OUT for a misaligned pc) with no IDLE bubble.
- Latency:
  - pc_update in cycle N with the block idle gives imem_req=1 in cycle N+2.
  - With gnt in N+2 and rvalid in N+3, inst_valid=1 in N+4.
- Simultaneous events:
  - pc_update in the same cycle the slot is consumed: the new pc goes into the slot, so pend_valid stays 1.
  - imem_gnt together with imem_rvalid in the same cycle is illegal from memory; rvalid is only sampled in WAIT.
- Flush (has priority over everything except rst):
  - Clears pend_valid, inst_valid and the OUT contents. A pc_update in the flush cycle is ignored.
  - In REQ with no gnt that cycle: drop imem_req and go to IDLE.
  - In REQ with gnt that cycle, or in WAIT: set the drop flag and stay in WAIT. The next rvalid is discarded, the drop flag clears, and the FSM goes to IDLE (or REQ if the slot has refilled).
  - A flush while draining keeps the drop flag set.
- Address width: imem_addr carries the full CPU_WIDTH pc; bits [1:0] are always 0 on any issued request.

Test Plan:
- Reset then single fetch: rst high 2 cycles → all outputs 0, fetch_rdy=1. pc_update with curr_pc=0x0000_0010 (cycle N), memory grants immediately and returns 0x0050_0093 one cycle later → imem_req in N+2 with imem_addr=0x10; inst_valid in N+4 with inst_pc=0x10, inst_data=0x0050_0093, inst_fault=0.
- Decode stall: inst_ready=0 for 5 cycles → inst_valid, inst_pc and inst_data held stable; second pc_update 0x14 → fetch_rdy drops to 0. On inst_ready=1 → next imem_req for 0x14 with no IDLE bubble.
- Overwrite: two pc_updates (0x20 then 0x40) while in WAIT → only 0x40 is fetched; 0x20 never appears on imem_addr.
- Misaligned pc 0x0000_0022 → no imem_req; inst_valid with inst_data=0x0000_0013, inst_fault=2'b10.
- Bus error: imem_rvalid with imem_err=1 and rdata=0xDEAD_BEEF → inst_data=0x0000_0013, inst_fault=2'b01.
- Flush in WAIT with pc_update 0x80 the next cycle → the stale rvalid (0x1111_1111) is discarded and never reaches inst_valid; the next inst_valid carries inst_pc=0x80. Reset asserted in WAIT → everything back to reset values, and a late rvalid is ignored.
